// File: rtl/vl_pkg.sv
// Shared types and constants for the vector beat path.
package vl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;
  localparam logic [1:0] SEW_64 = 2'b11;

  function automatic int bpb(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/vl_tail_mask.sv
// Byte-enable mask for a beat with i_rem bytes left; values >= BPB give all ones.
module vl_tail_mask
  import vl_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int REM_W      = 14
) (
  input  logic [REM_W-1:0]        i_rem,
  output logic [DATA_WIDTH/8-1:0] o_be
);

  localparam int BPB = bpb(DATA_WIDTH);

  always_comb begin
    o_be = '0;
    for (int i = 0; i < BPB; i++) begin
      o_be[i] = (i_rem > REM_W'(i));
    end
  end

endmodule

// File: rtl/vl_beat_gen.sv
// Beat sequencer: splits one vector operation of avl elements into DATA_WIDTH beats.
module vl_beat_gen
  import vl_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int VLEN          = 16384,
  parameter int DATA_WIDTH    = 64,
  parameter int VLMAX         = VLEN >> 3,
  parameter int VLEN_B_BITS   = $clog2(VLMAX),
  parameter bit ENABLE_64_BIT = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [VLEN_B_BITS-1:0]    avl,
  input  logic [1:0]                sew,
  input  logic                      vill,
  output logic                      busy,
  output logic                      beat_valid,
  input  logic                      beat_ready,
  output logic [VLEN_B_BITS-1:0]    beat_idx,
  output logic [DATA_WIDTH/8-1:0]   beat_be,
  output logic                      beat_first,
  output logic                      beat_last,
  output logic                      done,
  output logic                      err
);

  localparam int BPB   = bpb(DATA_WIDTH);
  localparam int TOT_W = VLEN_B_BITS + 3;

  state_t                 r_state, w_state_nxt;
  logic [TOT_W-1:0]       r_rem, w_rem_nxt;
  logic [VLEN_B_BITS-1:0] r_idx, w_idx_nxt;
  logic                   r_err, w_err_nxt;

  logic [TOT_W-1:0]        w_tot;
  logic                    w_legal;
  logic                    w_last;
  logic                    w_run;
  logic [DATA_WIDTH/8-1:0] w_be;

  // Widen before shifting so avl << 3 never truncates.
  assign w_tot   = TOT_W'(avl) << sew;
  assign w_legal = !vill && !((sew == SEW_64) && !ENABLE_64_BIT);
  assign w_last  = (r_rem <= TOT_W'(BPB));
  assign w_run   = (r_state == RUN);

  vl_tail_mask #(
    .DATA_WIDTH (DATA_WIDTH),
    .REM_W      (TOT_W)
  ) u_tail_mask (
    .i_rem (r_rem),
    .o_be  (w_be)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_idx_nxt   = r_idx;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (!w_legal) begin
            w_err_nxt = 1'b1;
          end else begin
            w_rem_nxt   = w_tot;
            w_idx_nxt   = '0;
            w_state_nxt = (w_tot == '0) ? DONE : RUN;
          end
        end
      end
      RUN: begin
        if (beat_ready) begin
          if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_rem_nxt = r_rem - TOT_W'(BPB);
            w_idx_nxt = r_idx + VLEN_B_BITS'(1);
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_idx   <= w_idx_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Beat fields are forced to zero outside RUN so idle outputs match reset values.
  assign busy       = (r_state != IDLE);
  assign beat_valid = w_run;
  assign beat_idx   = w_run ? r_idx : '0;
  assign beat_be    = w_run ? w_be : '0;
  assign beat_first = w_run && (r_idx == '0);
  assign beat_last  = w_run && w_last;
  assign done       = (r_state == DONE);
  assign err        = r_err;

endmodule

// File: tb/tb_vl_beat_gen.sv
// Randomized self-checking bench for vl_beat_gen against a byte-count reference model.
module tb_vl_beat_gen;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst, start, vill, beat_ready;
  logic [AW-1:0] avl;
  logic [1:0]    sew;
  logic          busy, beat_valid, beat_first, beat_last, done, err;
  logic [AW-1:0] beat_idx;
  logic [7:0]    beat_be;

  int total = 0;
  int bad   = 0;

  vl_beat_gen #(.ENABLE_64_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .avl(avl), .sew(sew), .vill(vill),
    .busy(busy), .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_idx(beat_idx), .beat_be(beat_be), .beat_first(beat_first),
    .beat_last(beat_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // ready_mode: 0 = always ready, 1 = pattern 1,0,0,1,0,1, 2 = random.
  // noise: re-assert start with junk avl/sew while the op runs.
  task automatic run_op(input int a, input int s, input int ready_mode, input bit noise, input string tag);
    int tot, nbeats, k, cyc, bytes;
    bit rdy;
    logic [7:0] exp_be;
    logic [AW-1:0] exp_idx;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tot    = a * (1 << s);
    nbeats = (tot + 7) / 8;
    start = 1'b1; avl = AW'(a); sew = 2'(s); vill = 1'b0; beat_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got=%b want=1", tag, busy); end
    if (nbeats == 0) begin
      total++;
      if (done !== 1'b1 || beat_valid !== 1'b0) begin
        bad++; $display("FAIL %s zero_len got done=%b valid=%b want done=1 valid=0", tag, done, beat_valid);
      end
    end else begin
      k = 0; cyc = 0;
      while (k < nbeats) begin
        bytes   = tot - 8 * k;
        exp_be  = (bytes >= 8) ? 8'hFF : 8'((1 << bytes) - 1);
        exp_idx = AW'(k);
        total++;
        if (beat_valid !== 1'b1 || beat_idx !== exp_idx || beat_be !== exp_be ||
            beat_first !== (k == 0) || beat_last !== (k == nbeats - 1) || done !== 1'b0) begin
          bad++;
          $display("FAIL %s beat%0d got v=%b idx=%0d be=%h f=%b l=%b d=%b want v=1 idx=%0d be=%h f=%b l=%b d=0",
                   tag, k, beat_valid, beat_idx, beat_be, beat_first, beat_last, done,
                   exp_idx, exp_be, (k == 0), (k == nbeats - 1));
        end
        case (ready_mode)
          0:       rdy = 1'b1;
          1:       rdy = pat[cyc % 6];
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        beat_ready = rdy;
        if (noise) begin
          start = 1'($urandom_range(0, 1)); avl = AW'($urandom_range(1, 60)); sew = 2'($urandom_range(0, 2));
        end
        @(negedge clk);
        start = 1'b0;
        if (rdy) k++;
        cyc++;
        if (cyc > nbeats * 40 + 50) begin
          total++; bad++;
          $display("FAIL %s timeout handshakes=%0d want=%0d", tag, k, nbeats);
          break;
        end
      end
      beat_ready = 1'b0;
      total++;
      if (done !== 1'b1 || beat_valid !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL %s done_pulse got done=%b valid=%b busy=%b want 1 0 1", tag, done, beat_valid, busy);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s back_idle got done=%b busy=%b want 0 0", tag, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; avl = '0; sew = '0; vill = 1'b0; beat_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, beat_valid, beat_first, beat_last, done, err} !== 6'b0 || beat_idx !== '0 || beat_be !== 8'h00) begin
      bad++;
      $display("FAIL reset got busy=%b v=%b f=%b l=%b d=%b e=%b idx=%0d be=%h want all 0",
               busy, beat_valid, beat_first, beat_last, done, err, beat_idx, beat_be);
    end
  endtask

  task automatic test_directed();
    run_op(20, 0, 0, 1'b0, "avl20_sew8");
    run_op(4, 2, 0, 1'b0, "avl4_sew32");
    run_op(3, 1, 0, 1'b0, "avl3_sew16");
    run_op(0, 1, 0, 1'b0, "avl0");
  endtask

  task automatic test_stall();
    run_op(20, 0, 1, 1'b0, "stall_pattern");
  endtask

  task automatic test_illegal();
    for (int t = 0; t < 2; t++) begin
      start = 1'b1; avl = AW'(16);
      vill = (t == 0); sew = (t == 0) ? 2'b00 : 2'b11;
      @(negedge clk);
      start = 1'b0; vill = 1'b0;
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || beat_valid !== 1'b0) begin
        bad++; $display("FAIL illegal%0d pulse got err=%b busy=%b done=%b v=%b want 1 0 0 0", t, err, busy, done, beat_valid);
      end
      @(negedge clk);
      total++;
      if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL illegal%0d after got err=%b busy=%b done=%b want 0 0 0", t, err, busy, done);
      end
    end
  endtask

  task automatic test_ignore_start();
    run_op(20, 0, 2, 1'b1, "restart_ignored");
    run_op(9, 2, 0, 1'b1, "restart_ignored2");
  endtask

  task automatic test_reset_mid();
    start = 1'b1; avl = AW'(20); sew = 2'b00; vill = 1'b0;
    @(negedge clk);
    start = 1'b0; beat_ready = 1'b1;
    @(negedge clk);
    beat_ready = 1'b0;
    total++;
    if (beat_valid !== 1'b1 || beat_idx !== AW'(1)) begin
      bad++; $display("FAIL rst_mid setup got v=%b idx=%0d want v=1 idx=1", beat_valid, beat_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, beat_valid, beat_first, beat_last, done, err} !== 6'b0 || beat_idx !== '0 || beat_be !== 8'h00) begin
      bad++; $display("FAIL rst_mid outputs got busy=%b v=%b d=%b idx=%0d be=%h want all 0", busy, beat_valid, done, beat_idx, beat_be);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid no_done got done=%b busy=%b want 0 0", done, busy);
    end
    run_op(20, 0, 0, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      run_op(int'($urandom_range(0, 40)), int'($urandom_range(0, 2)), 2, 1'($urandom_range(0, 1)), "random");
    end
    run_op(300, 2, 0, 1'b0, "long_sew32");
    run_op(2047, 0, 0, 1'b0, "max_avl_sew8");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_illegal();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vl_beat_gen.md
# vl_beat_gen

Beat sequencer directly downstream of the vector configuration unit. It takes the committed application vector length and SEW, and on each vector operation launch emits the sequence of `DATA_WIDTH`-wide data beats covering `avl` elements. Each beat carries a beat index, a byte-enable mask and first/last flags. Lane, load/store and writeback units consume this stream over a valid/ready handshake.

## Interface
Parameters:
- `XLEN`, 32, scalar register width (pass-through, unused internally)
- `VLEN`, 16384, vector register length in bits
- `DATA_WIDTH`, 64, datapath beat width in bits; power of two, ≥ 64
- `VLMAX`, `VLEN >> 3`, maximum vector length in bytes
- `VLEN_B_BITS`, `$clog2(VLMAX)`, width of `avl` and the beat index
- `ENABLE_64_BIT`, 1, SEW=64 support; when 0, `sew` = 2'b11 is illegal

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  launch one operation; sampled only in IDLE
- `avl`  in  VLEN_B_BITS  element count from the config unit
- `sew`  in  2  element width code: 00=8b, 01=16b, 10=32b, 11=64b
- `vill`  in  1  illegal vtype flag from the config unit
- `busy`  out  1  high in every state except IDLE
- `beat_valid`  out  1  beat outputs valid
- `beat_ready`  in  1  consumer accepts beat
- `beat_idx`  out  VLEN_B_BITS  beat number, 0-based
- `beat_be`  out  DATA_WIDTH/8  byte enables, bit i = byte i
- `beat_first`  out  1  beat 0 of the operation
- `beat_last`  out  1  final beat of the operation
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle illegal-launch pulse

## Operation
- BPB = DATA_WIDTH/8 bytes per beat.
- On launch, latch `tot = avl << sew`, computed at VLEN_B_BITS+3 bits with no truncation. Load `rem = tot` and `idx = 0`.
- Launch is illegal if `vill` = 1, or if `sew` = 11 with ENABLE_64_BIT = 0. An illegal launch pulses `err` the next cycle, emits no beats, does not pulse `done`, and stays in IDLE.
- FSM:
  - IDLE: `start` & legal & `tot` ≠ 0 → RUN.
  - IDLE: `start` & legal & `tot` = 0 → DONE.
  - RUN: present the current beat. On handshake with `beat_last` → DONE. On any other handshake: `rem -= BPB`, `idx += 1`, stay in RUN.
  - DONE: `done` = 1 for exactly one cycle → IDLE.
- Beat fields in RUN:
  - `beat_last` = (`rem` ≤ BPB).
  - `beat_be` = all ones if `rem` ≥ BPB, else `(1 << rem) - 1`.
  - `beat_first` = (`idx` == 0).
  - `beat_idx` = `idx`.
- `start` while `busy` is ignored, with no queuing. Changes to `avl`/`sew` after launch have no effect on the running operation.
- While `beat_valid` & ~`beat_ready`, all beat outputs hold stable. `beat_valid` never drops without a handshake, except on reset.

## Timing
- Reset values: state IDLE; `busy`, `beat_valid`, `beat_first`, `beat_last`, `done`, `err` = 0; `beat_idx` = 0; `beat_be` = 0; `rem` = 0.
- `rst` during RUN or DONE aborts on the same edge: no `done`, and the in-flight beat is dropped.
- `start` accepted at edge N:
  - `busy` and `beat_valid` are high from cycle N+1.
  - For `tot` = 0, `done` is high in cycle N+1.
  - For an illegal launch, `err` is high in cycle N+1.
- Throughput: 1 beat/cycle with `beat_ready` held high.
- Final handshake at edge M: `done` is high in cycle M+1, and `beat_valid` is low in cycle M+1.
- `busy` falls in cycle M+2, after DONE. The earliest next `start` is sampled at edge M+2.
- All outputs are registered or decoded from registered state only. There is no combinational path from `start`, `avl` or `sew` to any output.
- `beat_ready` may combinationally affect only next-state logic, never same-cycle outputs.

## Structure
- Shared package `vl_pkg`:
  - state enum {IDLE, RUN, DONE}
  - SEW code localparams (`SEW_8`, `SEW_16`, `SEW_32`, `SEW_64`)
  - function `bpb(DATA_WIDTH)`
- Sub-module `vl_tail_mask`: combinational, maps `rem` (clamped to BPB) to `beat_be`. It is reused by the load/store unit for partial transfers.
- Top level holds the FSM, `rem`/`idx` counters and legality check.

## Test plan
- DATA_WIDTH=64, `sew`=00, `avl`=20 → 3 beats; `beat_be` = FF, FF, 0F; `beat_idx` 0, 1, 2; first on beat 0, last on beat 2; `done` one cycle after the third handshake.
- `sew`=10, `avl`=4 (16 bytes) → 2 beats, both FF, last on beat 1. `sew`=01, `avl`=3 → 1 beat, `beat_be`=3F, first and last both set.
- Same as the first case with `beat_ready` toggled 1,0,0,1,0,1 → outputs stable during stalls, exactly 3 handshakes, identical field sequence.
- `avl`=0 → no `beat_valid`, `done` pulse at N+1. `vill`=1 → `err` pulse, no `done`, `busy` stays 0. `sew`=11 with ENABLE_64_BIT=0 → `err` pulse, no `done`, `busy` stays 0.
- `start` re-asserted mid-operation with new `avl` → ignored, original beat count completes.
- `rst` asserted during beat 1 of a 3-beat op → next cycle all outputs at reset values, no `done`. A subsequent `start` runs a clean operation from `beat_idx` 0.
